// File: rtl/mem_port_arbiter_if.sv
// One request/response channel: a requester (master) issues requests and a responder (slave) returns data.
// Handshake: a request transfers in the cycle where req_valid && req_ready; resp_valid is a single-cycle pulse.
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 64
);
   logic                  req_valid;
   logic                  req_ready;
   logic [ADDR_W-1:0]     req_addr;
   logic                  req_wen;
   logic [DATA_W-1:0]     req_wdata;
   logic [DATA_W/8-1:0]   req_wmask;
   logic                  resp_valid;
   logic [DATA_W-1:0]     resp_data;

   modport master (
      output req_valid, req_addr, req_wen, req_wdata, req_wmask,
      input  req_ready, resp_valid, resp_data
   );

   modport slave (
      input  req_valid, req_addr, req_wen, req_wdata, req_wmask,
      output req_ready, resp_valid, resp_data
   );

   // Read-only requester view: instruction fetch never writes.
   modport read_slave (
      input  req_valid, req_addr,
      output req_ready, resp_valid, resp_data
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store, one transaction at a time.
// Load/store has priority; IF is force-granted after STARVE_MAX consecutive losses.
module mem_port_arbiter #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 64,
   parameter int STARVE_MAX = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   mem_port_arbiter_if.read_slave    if_port,
   mem_port_arbiter_if.slave         ls_port,
   mem_port_arbiter_if.master        mem_port,
   output logic                      owner,
   output logic                      busy,
   output logic [1:0]                dbg_state_o
);
   localparam int MASK_W = DATA_W / 8;
   localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2
   } state_e;

   state_e              state_q, state_d;
   logic [3:0]          starve_cnt_q, starve_cnt_d;
   logic                owner_q, owner_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic                wen_q, wen_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [MASK_W-1:0]   wmask_q, wmask_d;
   logic [DATA_W-1:0]   if_data_q, if_data_d;
   logic [DATA_W-1:0]   ls_data_q, ls_data_d;

   logic grant_if;
   logic grant_ls;
   logic resp_fire;

   // Grants are combinational in IDLE and suppressed while reset is asserted.
   always_comb begin
      grant_if  = (state_q == ST_IDLE) && !rst && if_port.req_valid &&
                  (!ls_port.req_valid || (starve_cnt_q == STARVE_LIM));
      grant_ls  = (state_q == ST_IDLE) && !rst && ls_port.req_valid && !grant_if;
      resp_fire = (state_q == ST_WAIT) && mem_port.resp_valid;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: if (grant_if || grant_ls) state_d = ST_REQ;
         ST_REQ:  if (mem_port.req_ready)   state_d = ST_WAIT;
         ST_WAIT: if (mem_port.resp_valid)  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      starve_cnt_d = starve_cnt_q;
      owner_d      = owner_q;
      addr_d       = addr_q;
      wen_d        = wen_q;
      wdata_d      = wdata_q;
      wmask_d      = wmask_q;
      if_data_d    = if_data_q;
      ls_data_d    = ls_data_q;
      if (grant_if) begin
         owner_d      = 1'b0;
         addr_d       = if_port.req_addr;
         wen_d        = 1'b0;
         wdata_d      = '0;
         wmask_d      = '0;
         starve_cnt_d = '0;
      end else if (grant_ls) begin
         owner_d = 1'b1;
         addr_d  = ls_port.req_addr;
         wen_d   = ls_port.req_wen;
         wdata_d = ls_port.req_wdata;
         wmask_d = ls_port.req_wmask;
         // Only a waiting IF counts as a loss.
         if (if_port.req_valid && (starve_cnt_q != STARVE_LIM)) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
         end
      end
      if (resp_fire) begin
         if (owner_q) begin
            ls_data_d = wen_q ? '0 : mem_port.resp_data;
         end else begin
            if_data_d = mem_port.resp_data;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         starve_cnt_q <= '0;
         owner_q      <= 1'b0;
         addr_q       <= '0;
         wen_q        <= 1'b0;
         wdata_q      <= '0;
         wmask_q      <= '0;
         if_data_q    <= '0;
         ls_data_q    <= '0;
      end else begin
         starve_cnt_q <= starve_cnt_d;
         owner_q      <= owner_d;
         addr_q       <= addr_d;
         wen_q        <= wen_d;
         wdata_q      <= wdata_d;
         wmask_q      <= wmask_d;
         if_data_q    <= if_data_d;
         ls_data_q    <= ls_data_d;
      end
   end

   // Response data is visible in the pulse cycle and held afterwards.
   always_comb begin
      if_port.req_ready   = grant_if;
      ls_port.req_ready   = grant_ls;
      mem_port.req_valid  = (state_q == ST_REQ);
      mem_port.req_addr   = addr_q;
      mem_port.req_wen    = wen_q;
      mem_port.req_wdata  = wdata_q;
      mem_port.req_wmask  = wmask_q;
      if_port.resp_valid  = resp_fire && !owner_q;
      ls_port.resp_valid  = resp_fire && owner_q;
      if_port.resp_data   = if_data_d;
      ls_port.resp_data   = ls_data_d;
      owner               = owner_q;
      busy                = (state_q != ST_IDLE);
      dbg_state_o         = state_q;
   end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed fetch/store/reset cases, then randomized traffic
// checked every cycle against a transaction-level model of the shared port.
module tb_mem_port_arbiter;
   localparam int ADDR_W     = 32;
   localparam int DATA_W     = 64;
   localparam int MASK_W     = DATA_W / 8;
   localparam int STARVE_MAX = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic       owner;
   logic       busy;
   logic [1:0] dbg_state;

   always #5 clk = ~clk;

   mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) if_bus (), ls_bus (), mem_bus ();

   mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX)) dut (
      .clk         (clk),
      .rst         (rst),
      .if_port     (if_bus),
      .ls_port     (ls_bus),
      .mem_port    (mem_bus),
      .owner       (owner),
      .busy        (busy),
      .dbg_state_o (dbg_state)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference model: the port is free, holds a transaction not yet taken by memory, or awaits its data.
   typedef enum {PH_FREE, PH_PENDING, PH_ISSUED} phase_e;
   phase_e              ph = PH_FREE;
   int                  losses = 0;
   logic                m_owner = 1'b0;
   logic [ADDR_W-1:0]   m_addr = '0;
   logic                m_wen = 1'b0;
   logic [DATA_W-1:0]   m_wdata = '0;
   logic [MASK_W-1:0]   m_wmask = '0;
   logic [DATA_W-1:0]   last_if = '0;
   logic [DATA_W-1:0]   last_ls = '0;
   logic [ADDR_W-1:0]   exp_q[$];
   bit                  if_gnt = 1'b0;
   bit                  ls_gnt = 1'b0;
   bit                  exp_if_rv, exp_ls_rv, win_if, win_ls, done;
   int                  n_resp = 0;
   int                  n_forced = 0;

   always @(negedge clk) begin
      if_gnt = 1'b0;
      ls_gnt = 1'b0;
      if (rst) begin
         ph = PH_FREE; losses = 0; m_owner = 1'b0; m_addr = '0; m_wen = 1'b0;
         m_wdata = '0; m_wmask = '0; last_if = '0; last_ls = '0;
         exp_q.delete();
      end else begin
         exp_if_rv = 1'b0;
         exp_ls_rv = 1'b0;
         done = (ph == PH_ISSUED) && mem_bus.resp_valid;
         if (done) begin
            n_resp++;
            if (m_owner) begin
               exp_ls_rv = 1'b1;
               last_ls = m_wen ? '0 : mem_bus.resp_data;
            end else begin
               exp_if_rv = 1'b1;
               last_if = mem_bus.resp_data;
            end
         end
         check("if_resp_valid", if_bus.resp_valid, exp_if_rv);
         check("ls_resp_valid", ls_bus.resp_valid, exp_ls_rv);
         check("if_resp_data", if_bus.resp_data, last_if);
         check("ls_resp_data", ls_bus.resp_data, last_ls);

         win_if = 1'b0;
         win_ls = 1'b0;
         if (ph == PH_FREE) begin
            if (if_bus.req_valid && ls_bus.req_valid) begin
               if (losses >= STARVE_MAX) win_if = 1'b1;
               else win_ls = 1'b1;
            end else begin
               win_if = if_bus.req_valid;
               win_ls = ls_bus.req_valid;
            end
         end
         check("if_req_ready", if_bus.req_ready, win_if);
         check("ls_req_ready", ls_bus.req_ready, win_ls);
         check("mem_req_valid", mem_bus.req_valid, ph == PH_PENDING);
         check("mem_req_addr", mem_bus.req_addr, m_addr);
         check("mem_req_wen", mem_bus.req_wen, m_wen);
         check("mem_req_wdata", mem_bus.req_wdata, m_wdata);
         check("mem_req_wmask", mem_bus.req_wmask, m_wmask);
         check("busy", busy, ph != PH_FREE);
         check("owner", owner, m_owner);

         if (ph == PH_PENDING && mem_bus.req_ready) begin
            if (exp_q.size() == 0) check("mem_order_empty", 1, 0);
            else check("mem_order_addr", mem_bus.req_addr, exp_q.pop_front());
            ph = PH_ISSUED;
         end else if (done) begin
            ph = PH_FREE;
         end else if (win_if || win_ls) begin
            if (win_if) begin
               if (ls_bus.req_valid) n_forced++;
               losses = 0;
               m_owner = 1'b0; m_addr = if_bus.req_addr; m_wen = 1'b0; m_wdata = '0; m_wmask = '0;
            end else begin
               if (if_bus.req_valid && losses < STARVE_MAX) losses++;
               m_owner = 1'b1; m_addr = ls_bus.req_addr; m_wen = ls_bus.req_wen;
               m_wdata = ls_bus.req_wdata; m_wmask = ls_bus.req_wmask;
            end
            exp_q.push_back(m_addr);
            if_gnt = win_if;
            ls_gnt = win_ls;
            ph = PH_PENDING;
         end
      end
   end

   int p_if, p_ls, p_rdy, p_resp, p_rst;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_random();
      step();
      rst = ($urandom_range(99) < p_rst) && (ph == PH_ISSUED);
      if (if_gnt || !if_bus.req_valid || $urandom_range(99) < 10) begin
         if_bus.req_valid = $urandom_range(99) < p_if;
         if_bus.req_addr  = $urandom & 32'hFFFF_FFF8;
      end
      if (ls_gnt || !ls_bus.req_valid || $urandom_range(99) < 10) begin
         ls_bus.req_valid = $urandom_range(99) < p_ls;
         ls_bus.req_addr  = $urandom & 32'hFFFF_FFF8;
         ls_bus.req_wen   = $urandom_range(1);
         ls_bus.req_wdata = {$urandom, $urandom};
         ls_bus.req_wmask = MASK_W'($urandom);
      end
      mem_bus.req_ready  = $urandom_range(99) < p_rdy;
      mem_bus.resp_valid = $urandom_range(99) < p_resp;
      mem_bus.resp_data  = {$urandom, $urandom};
   endtask

   task automatic idle_inputs();
      if_bus.req_valid = 1'b0; if_bus.req_addr = '0; if_bus.req_wen = 1'b0;
      if_bus.req_wdata = '0; if_bus.req_wmask = '0;
      ls_bus.req_valid = 1'b0; ls_bus.req_addr = '0; ls_bus.req_wen = 1'b0;
      ls_bus.req_wdata = '0; ls_bus.req_wmask = '0;
      mem_bus.req_ready = 1'b0; mem_bus.resp_valid = 1'b0; mem_bus.resp_data = '0;
   endtask

   // Knobs per random phase: if%, ls%, mem ready%, mem resp%, reset-in-wait%.
   int knobs[4][5] = '{'{60, 60, 70, 50, 0}, '{100, 100, 100, 100, 0},
                       '{50, 50, 30, 30, 3}, '{30, 80, 90, 60, 0}};

   initial begin
      rst = 1'b1;
      idle_inputs();
      repeat (3) step();
      rst = 1'b0;
      @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_owner", owner, 0);
      check("rst_mem_valid", mem_bus.req_valid, 0);

      // IF-only fetch with an always-ready memory.
      step();
      if_bus.req_valid = 1'b1; if_bus.req_addr = 32'h8000_0000; mem_bus.req_ready = 1'b1;
      @(negedge clk);
      check("t1_if_ready_c0", if_bus.req_ready, 1);
      step();
      if_bus.req_valid = 1'b0;
      @(negedge clk);
      check("t1_mem_valid_c1", mem_bus.req_valid, 1);
      check("t1_mem_addr_c1", mem_bus.req_addr, 32'h8000_0000);
      step();
      mem_bus.resp_valid = 1'b1; mem_bus.resp_data = 64'h1234;
      @(negedge clk);
      check("t1_if_resp_c2", if_bus.resp_valid, 1);
      check("t1_if_data_c2", if_bus.resp_data, 64'h1234);
      check("t1_ls_resp_c2", ls_bus.resp_valid, 0);
      step();
      mem_bus.resp_valid = 1'b0;

      // Store held in REQ by a slow memory.
      ls_bus.req_valid = 1'b1; ls_bus.req_wen = 1'b1; ls_bus.req_addr = 32'h0000_0100;
      ls_bus.req_wdata = 64'hAABB; ls_bus.req_wmask = 8'h0F; mem_bus.req_ready = 1'b0;
      @(negedge clk);
      check("t4_ls_ready", ls_bus.req_ready, 1);
      step();
      ls_bus.req_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         mem_bus.req_ready = (i == 3);
         @(negedge clk);
         check("t4_req_valid", mem_bus.req_valid, 1);
         check("t4_req_wen", mem_bus.req_wen, 1);
         check("t4_req_wdata", mem_bus.req_wdata, 64'hAABB);
         check("t4_req_wmask", mem_bus.req_wmask, 8'h0F);
         step();
      end
      mem_bus.req_ready = 1'b0; mem_bus.resp_valid = 1'b1; mem_bus.resp_data = 64'hDEAD_BEEF;
      @(negedge clk);
      check("t4_ls_resp", ls_bus.resp_valid, 1);
      check("t4_ls_data", ls_bus.resp_data, 0);
      step();
      mem_bus.resp_valid = 1'b0;

      // Reset while waiting for data, then a late response.
      if_bus.req_valid = 1'b1; if_bus.req_addr = 32'h0000_2000; mem_bus.req_ready = 1'b1;
      step();
      if_bus.req_valid = 1'b0;
      step();
      rst = 1'b1;
      step();
      rst = 1'b0; mem_bus.resp_valid = 1'b1; mem_bus.resp_data = 64'h5555;
      @(negedge clk);
      check("t5_if_resp", if_bus.resp_valid, 0);
      check("t5_if_data", if_bus.resp_data, 0);
      check("t5_busy", busy, 0);
      check("t5_mem_addr", mem_bus.req_addr, 0);
      check("t5_state", dbg_state, 0);
      step();
      idle_inputs();

      for (int ph_i = 0; ph_i < 4; ph_i++) begin
         p_if = knobs[ph_i][0]; p_ls = knobs[ph_i][1]; p_rdy = knobs[ph_i][2];
         p_resp = knobs[ph_i][3]; p_rst = knobs[ph_i][4];
         repeat (1500) drive_random();
      end
      step();
      rst = 1'b0;
      idle_inputs();
      @(negedge clk);

      check("progress", n_resp > 200, 1);
      check("starve_forced", n_forced > 0, 1);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
